shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences an iterative 1-bit-per-cycle shifter for operand2 of data-processing instructions.
- Decodes the 8-bit shift field (instruction bits 11-4), resolves immediate vs register amounts, and applies ARM corner cases (LSR/ASR #0 = #32, ROR #0 = RRX, amounts >= 32).
- Produces the shifted value and shifter carry-out.
- Sits between the decode stage and the ALU, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported: the corner-case rules are tied to it.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-low reset; sampled on the rising edge of clk.
- req_valid, input, 1, request present.
- req_ready, output, 1, sequencer can accept a request.
- sh_field, input, 8, instruction bits 11-4:
  - [7:3] imm amount.
  - [2:1] type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - [0] 1 = amount taken from rs_val.
- data_in, input, 32, value to shift (Rm).
- rs_val, input, 8, Rs[7:0]; used only when sh_field[0]=1.
- c_in, input, 1, current CPSR C flag.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer takes result.
- result, output, 32, shifted value.
- c_out, output, 1, shifter carry-out.
- busy, output, 1, high in SHIFT or DONE.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; result=0, c_out=0, res_valid=0, busy=0, req_ready=1. Reset wins over every other event, including mid-SHIFT and DONE; any in-flight request is dropped.
- States: IDLE, SHIFT, DONE.
  - req_ready=1 only in IDLE.
  - res_valid=1 only in DONE.
  - busy = (state != IDLE).
- Accept: req_valid and req_ready high at edge E0.
  - Latch data_in into acc, c_in into cy, and the type.
  - Compute raw amount A: sh_field[0] ? rs_val : {3'b0, sh_field[7:3]}.
  - Compute step count N per the rules below.
- Immediate (sh_field[0]=0):
  - LSL A=0: N=0, acc unchanged, cy=c_in.
  - LSR A=0: treated as 32.
  - ASR A=0: treated as 32.
  - ROR A=0: RRX, N=1, result={c_in, acc[31:1]}, cy=acc[0].
- Register (sh_field[0]=1):
  - A=0 (any type): N=0, acc unchanged, cy=c_in.
  - LSL/LSR: N=min(A,33). 32 steps move the last bit into cy; the 33rd step clears cy.
  - ASR: N=min(A,32).
  - ROR: N=A[4:0]. If A[4:0]=0 and A!=0: N=0, acc unchanged, cy=acc[31].
- Per SHIFT step (one edge), where cy receives the bit shifted out:
  - LSL: cy=acc[31], acc=acc<<1.
  - LSR: cy=acc[0], acc=acc>>1.
  - ASR: cy=acc[0], acc={acc[31], acc[31:1]}.
  - ROR: cy=acc[0], acc={acc[0], acc[31:1]}.
  - RRX: one step using the latched c_in.
- Transitions:
  - IDLE -> DONE at E0 if N=0; otherwise IDLE -> SHIFT with cnt=N.
  - In SHIFT: one step per edge, cnt decrements; the edge that steps with cnt=1 moves to DONE.
  - res_valid is first high after edge E_N, i.e. the latency is max(N,1) edges from the request cycle. Maximum is 33 steps.
- DONE:
  - result=acc and c_out=cy, held stable while res_ready=0.
  - On the edge with res_ready=1: go to IDLE.
  - A new request is accepted no earlier than the next edge; there is no same-cycle turnaround.
- Inputs are ignored outside IDLE. Changing data_in mid-operation has no effect.
- result and c_out keep their last values in IDLE and SHIFT; they are not cleared between requests.

Test Plan:
- Reset with rst=0 for 2 cycles, then release. Issue LSL #4 (sh_field=0x20), data_in=0x8000_000F, c_in=0. Required: req_ready=1 after release; res_valid after 4 edges; result=0x0000_00F0, c_out=0; back to IDLE after res_ready=1.
- LSR #0 imm (0x02), data_in=0x8000_0001, c_in=0. Required: 32 steps, result=0, c_out=1. Repeat with ASR #0 imm (0x04): result=0xFFFF_FFFF, c_out=1.
- RRX (0x06), data_in=0x0000_0003, c_in=1. Required: result=0x8000_0001, c_out=1, latency 1.
- Register LSL (0x01) with rs_val=33, data_in=0xFFFF_FFFF: result=0, c_out=0. Then rs_val=0, c_in=1: result=data_in, c_out=1, latency 1. Then ROR reg (0x07) with rs_val=64, data_in=0x8000_0000: result=0x8000_0000, c_out=1.
- Backpressure: complete ROR #8 (0x46) on 0x1234_5678 with res_ready=0 for 5 cycles. Required: result=0x7812_3456, c_out=0 held stable; req_ready=0 throughout, and a req_valid pulse during the stall is not accepted.
- Drive rst=0 at step 10 of an LSR #31 (0xFA). Required: IDLE on the next edge, res_valid=0, result=0, c_out=0. A following LSL #1 (0x08) on 0x1 gives result=0x2, c_out=0.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle operand2 barrel-shift replacement.
// Decodes the 8-bit shift field, resolves immediate/register amounts with the
// ARM corner cases, and shifts one bit per cycle behind valid/ready handshakes.
// WIDTH must be 32: the #0 / #32 / RRX rules assume a 32-bit datapath.
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       sh_field,
    input  logic [WIDTH-1:0] data_in,
    input  logic [7:0]       rs_val,
    input  logic             c_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_LSL,
        OP_LSR,
        OP_ASR,
        OP_ROR,
        OP_RRX
    } op_t;

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_acc;
    logic             r_cy;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_req_ready;
    logic             r_res_valid;
    logic             r_busy;

    logic [7:0]       w_amt;
    op_t              w_op;
    logic [5:0]       w_n;
    logic             w_zero_cy;
    logic [WIDTH:0]   w_first;
    logic [WIDTH:0]   w_next;

    // One shift step: returns {bit shifted out, shifted value}.
    function automatic logic [WIDTH:0] f_step(input op_t op, input logic [WIDTH-1:0] acc,
                                              input logic cy);
        logic [WIDTH:0] r;
        case (op)
            OP_LSL:  r = {acc[WIDTH-1], acc[WIDTH-2:0], 1'b0};
            OP_LSR:  r = {acc[0], 1'b0, acc[WIDTH-1:1]};
            OP_ASR:  r = {acc[0], acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROR:  r = {acc[0], acc[0], acc[WIDTH-1:1]};
            OP_RRX:  r = {acc[0], cy, acc[WIDTH-1:1]};
            default: r = {cy, acc};
        endcase
        return r;
    endfunction

    assign w_amt = sh_field[0] ? rs_val : {3'b000, sh_field[7:3]};

    // Decode shift type and step count N, plus the carry used when N=0.
    always_comb begin
        w_op      = OP_LSL;
        w_n       = '0;
        w_zero_cy = c_in;
        if (!sh_field[0]) begin
            case (sh_field[2:1])
                2'b00: begin
                    w_op = OP_LSL;
                    w_n  = w_amt[5:0];
                end
                2'b01: begin
                    w_op = OP_LSR;
                    w_n  = (w_amt == 8'd0) ? 6'd32 : w_amt[5:0];
                end
                2'b10: begin
                    w_op = OP_ASR;
                    w_n  = (w_amt == 8'd0) ? 6'd32 : w_amt[5:0];
                end
                default: begin
                    if (w_amt == 8'd0) begin
                        w_op = OP_RRX;
                        w_n  = 6'd1;
                    end else begin
                        w_op = OP_ROR;
                        w_n  = w_amt[5:0];
                    end
                end
            endcase
        end else if (w_amt != 8'd0) begin
            case (sh_field[2:1])
                2'b00: begin
                    w_op = OP_LSL;
                    w_n  = (w_amt > 8'd33) ? 6'd33 : w_amt[5:0];
                end
                2'b01: begin
                    w_op = OP_LSR;
                    w_n  = (w_amt > 8'd33) ? 6'd33 : w_amt[5:0];
                end
                2'b10: begin
                    w_op = OP_ASR;
                    w_n  = (w_amt > 8'd32) ? 6'd32 : w_amt[5:0];
                end
                default: begin
                    w_op = OP_ROR;
                    w_n  = {1'b0, w_amt[4:0]};
                    if (w_amt[4:0] == 5'd0) begin
                        w_zero_cy = data_in[WIDTH-1];
                    end
                end
            endcase
        end
    end

    assign w_first = f_step(w_op, data_in, c_in);
    assign w_next  = f_step(r_op, r_acc, r_cy);

    // Control FSM with datapath and registered handshake outputs.
    // The accept edge performs the first step itself, so SHIFT is loaded with
    // N-1; this keeps the result latency at max(N,1) edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LSL;
            r_acc       <= '0;
            r_cy        <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_c_out     <= 1'b0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op        <= w_op;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_n == 6'd0) begin
                            r_acc       <= data_in;
                            r_cy        <= w_zero_cy;
                            r_result    <= data_in;
                            r_c_out     <= w_zero_cy;
                            r_res_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_n == 6'd1) begin
                            {r_cy, r_acc}      <= w_first;
                            {r_c_out, r_result} <= w_first;
                            r_res_valid        <= 1'b1;
                            r_state            <= S_DONE;
                        end else begin
                            {r_cy, r_acc} <= w_first;
                            r_cnt         <= w_n - 6'd1;
                            r_state       <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    {r_cy, r_acc} <= w_next;
                    r_cnt         <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        {r_c_out, r_result} <= w_next;
                        r_res_valid         <= 1'b1;
                        r_state             <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign c_out     = r_c_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: closed-form shift model, per-cycle
// output comparison, directed corner cases and randomized transactions.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  sh_field = '0;
    logic [31:0] data_in = '0;
    logic [7:0]  rs_val = '0;
    logic        c_in = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] result;
    logic        c_out;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;
    logic [31:0] exp_res = '0;
    logic        exp_c = 1'b0;
    logic [31:0] hold_res = '0;
    logic        hold_c = 1'b0;

    shift_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .sh_field  (sh_field),
        .data_in   (data_in),
        .rs_val    (rs_val),
        .c_in      (c_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed-form ARM operand2 shifter: result, carry and step count N.
    function automatic void model(input logic [7:0] sh, input logic [31:0] d,
                                  input logic [7:0] rs, input logic cin,
                                  output logic [31:0] r, output logic c, output int n);
        int amt;
        int eff;
        logic [63:0] w;
        amt = sh[0] ? int'(rs) : int'(sh[7:3]);
        eff = amt;
        r = d;
        c = cin;
        n = 0;
        case (sh[2:1])
            2'b00: begin
                n = (eff > 33) ? 33 : eff;
                if (eff > 32) begin
                    r = 0; c = 0;
                end else if (eff > 0) begin
                    w = {32'b0, d} << eff;
                    r = w[31:0]; c = w[32];
                end
            end
            2'b01: begin
                if (!sh[0] && amt == 0) eff = 32;
                n = (eff > 33) ? 33 : eff;
                if (eff > 32) begin
                    r = 0; c = 0;
                end else if (eff > 0) begin
                    w = {d, 32'b0} >> eff;
                    r = w[63:32]; c = w[31];
                end
            end
            2'b10: begin
                if (!sh[0] && amt == 0) eff = 32;
                if (eff > 32) eff = 32;
                n = eff;
                if (eff > 0) begin
                    w = $signed({d, 32'b0}) >>> eff;
                    r = w[63:32]; c = w[31];
                end
            end
            default: begin
                if (!sh[0] && amt == 0) begin
                    r = {cin, d[31:1]}; c = d[0]; n = 1;
                end else if (amt != 0) begin
                    n = amt % 32;
                    if (n == 0) begin
                        c = d[31];
                    end else begin
                        w = {d, d} >> n;
                        r = w[31:0]; c = r[31];
                    end
                end
            end
        endcase
    endfunction

    // Every cycle: handshake consistency, and result/carry either the
    // expected DONE value or the held value from the previous result.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_vs_ready", busy, !req_ready);
            if (res_valid) begin
                check("valid_implies_busy", busy, 1);
                check("done_result", {result, c_out}, {exp_res, exp_c});
                hold_res = exp_res;
                hold_c   = exp_c;
            end else begin
                check("held_result", {result, c_out}, {hold_res, hold_c});
            end
        end
    end

    // Pin the model against hand-computed values.
    task automatic pin(input logic [7:0] sh, input logic [31:0] d, input logic [7:0] rs,
                       input logic cin, input logic [31:0] lr, input logic lc, input int ll);
        logic [31:0] r;
        logic        c;
        int          n;
        model(sh, d, rs, cin, r, c, n);
        check("model_result", r, lr);
        check("model_carry", c, lc);
        check("model_latency", (n == 0) ? 1 : n, ll);
    endtask

    // One full transaction with optional result backpressure and a stray request pulse.
    task automatic run(input logic [7:0] sh, input logic [31:0] d, input logic [7:0] rs,
                       input logic cin, input int stall, input bit pulse);
        logic [31:0] r;
        logic        c;
        int          n;
        int          cyc;
        model(sh, d, rs, cin, r, c, n);
        check("ready_before_req", req_ready, 1);
        exp_res   = r;
        exp_c     = c;
        sh_field  = sh;
        data_in   = d;
        rs_val    = rs;
        c_in      = cin;
        req_valid = 1'b1;
        res_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        data_in   = $urandom;
        sh_field  = 8'($urandom);
        rs_val    = 8'($urandom);
        c_in      = 1'($urandom);
        cyc = 1;
        while (!res_valid && cyc < 40) begin
            check("ready_low_busy", req_ready, 0);
            tick();
            cyc++;
        end
        check("latency", cyc, (n == 0) ? 1 : n);
        check("res_valid_seen", res_valid, 1);
        for (int i = 0; i < stall; i++) begin
            if (pulse && i == 1) req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            check("stall_valid", res_valid, 1);
            check("stall_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("back_to_idle", {req_ready, res_valid, busy}, 3'b100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] picks [6];
        logic [7:0] rs;
        picks[0] = 8'd0;  picks[1] = 8'd31; picks[2] = 8'd32;
        picks[3] = 8'd33; picks[4] = 8'd64; picks[5] = 8'd255;

        // Reset for two edges.
        rst = 1'b0;
        tick();
        tick();
        check("reset_outputs", {req_ready, res_valid, busy, result, c_out}, {3'b100, 32'h0, 1'b0});
        rst = 1'b1;
        hold_res = '0;
        hold_c   = 1'b0;
        chk_en   = 1'b1;
        tick();
        check("ready_after_reset", req_ready, 1);

        // Directed corner cases, model pinned to literals first.
        pin(8'h20, 32'h8000_000F, 8'h00, 1'b0, 32'h0000_00F0, 1'b0, 4);
        run(8'h20, 32'h8000_000F, 8'h00, 1'b0, 0, 1'b0);
        pin(8'h02, 32'h8000_0001, 8'h00, 1'b0, 32'h0000_0000, 1'b1, 32);
        run(8'h02, 32'h8000_0001, 8'h00, 1'b0, 0, 1'b0);
        pin(8'h04, 32'h8000_0001, 8'h00, 1'b0, 32'hFFFF_FFFF, 1'b1, 32);
        run(8'h04, 32'h8000_0001, 8'h00, 1'b0, 0, 1'b0);
        pin(8'h06, 32'h0000_0003, 8'h00, 1'b1, 32'h8000_0001, 1'b1, 1);
        run(8'h06, 32'h0000_0003, 8'h00, 1'b1, 0, 1'b0);
        pin(8'h01, 32'hFFFF_FFFF, 8'd33, 1'b0, 32'h0000_0000, 1'b0, 33);
        run(8'h01, 32'hFFFF_FFFF, 8'd33, 1'b0, 0, 1'b0);
        pin(8'h01, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1);
        run(8'h01, 32'hFFFF_FFFF, 8'd0, 1'b1, 0, 1'b0);
        pin(8'h07, 32'h8000_0000, 8'd64, 1'b0, 32'h8000_0000, 1'b1, 1);
        run(8'h07, 32'h8000_0000, 8'd64, 1'b0, 0, 1'b0);
        pin(8'h46, 32'h1234_5678, 8'h00, 1'b1, 32'h7812_3456, 1'b0, 8);
        run(8'h46, 32'h1234_5678, 8'h00, 1'b1, 5, 1'b1);

        // Reset at step 10 of LSR #31.
        sh_field  = 8'hFA;
        data_in   = 32'hFFFF_0000;
        c_in      = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        check("busy_mid_shift", busy, 1);
        chk_en = 1'b0;
        rst = 1'b0;
        tick();
        check("mid_reset_outputs", {req_ready, res_valid, busy, result, c_out}, {3'b100, 32'h0, 1'b0});
        rst = 1'b1;
        hold_res = '0;
        hold_c   = 1'b0;
        chk_en   = 1'b1;
        pin(8'h08, 32'h0000_0001, 8'h00, 1'b1, 32'h0000_0002, 1'b0, 1);
        run(8'h08, 32'h0000_0001, 8'h00, 1'b1, 0, 1'b0);

        // Randomized transactions.
        for (int k = 0; k < 200; k++) begin
            rs = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 5)]
                                             : 8'($urandom_range(0, 40));
            run(8'($urandom), $urandom, rs, 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
